exec_sequencer: RTL

- Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
- Sits directly upstream of the 4x8 register file: drives its read/write indices, write enable and write data, and consumes its two combinational read ports.
- Contains PC, instruction register, immediate register, Z/C flags, the ALU and the control FSM.
- Fetches instructions over a req/valid handshake from instruction memory.

---
 rtl/exec_sequencer_if.sv | 26 ++
 rtl/exec_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer_if.sv
// Bus between the exec sequencer and its neighbours: the instruction-memory
// fetch handshake and the 4x8 register file ports.
interface exec_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_data;
  logic              imem_valid;
  logic [1:0]        rf_in_1;
  logic [1:0]        rf_in_2;
  logic              rf_wen;
  logic [7:0]        rf_data;
  logic [7:0]        rf_out_1;
  logic [7:0]        rf_out_2;

  modport master (
    output imem_req, imem_addr, rf_in_1, rf_in_2, rf_wen, rf_data,
    input  imem_data, imem_valid, rf_out_1, rf_out_2
  );

  modport slave (
    input  imem_req, imem_addr, rf_in_1, rf_in_2, rf_wen, rf_data,
    output imem_data, imem_valid, rf_out_1, rf_out_2
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU: PC, IR, imm,
// Z/C flags, ALU and control FSM; writes results into an external 4x8 register file.
module exec_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  exec_sequencer_if.master   bus,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               halted
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_FETCH_IMM = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_HALT      = 3'd4;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        imm_q, imm_d;
  logic              z_q, z_d;
  logic              c_q, c_d;

  logic [3:0] opcode;
  logic       two_byte;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_wr;
  logic       alu_flags;

  assign opcode   = ir_q[7:4];
  assign two_byte = (opcode == OP_LDI) || (opcode == OP_JMP) || (opcode == OP_JZ);
  assign op_a     = bus.rf_out_1;
  assign op_b     = bus.rf_out_2;

  // Bit 8 of the 9-bit difference is set exactly when rs1 < rs2 unsigned (borrow).
  always_comb begin
    sum9      = {1'b0, op_a} + {1'b0, op_b};
    diff9     = {1'b0, op_a} - {1'b0, op_b};
    alu_res   = 8'h00;
    alu_c     = c_q;
    alu_wr    = 1'b0;
    alu_flags = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res   = sum9[7:0];
        alu_c     = sum9[8];
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_SUB: begin
        alu_res   = diff9[7:0];
        alu_c     = diff9[8];
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_AND: begin
        alu_res   = op_a & op_b;
        alu_c     = 1'b0;
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_OR: begin
        alu_res   = op_a | op_b;
        alu_c     = 1'b0;
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_XOR: begin
        alu_res   = op_a ^ op_b;
        alu_c     = 1'b0;
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_MOV: begin
        alu_res = op_b;
        alu_wr  = 1'b1;
      end
      OP_LDI: begin
        alu_res = imm_q;
        alu_wr  = 1'b1;
      end
      OP_SHL: begin
        alu_res   = {op_a[6:0], 1'b0};
        alu_c     = op_a[7];
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      OP_SHR: begin
        alu_res   = {1'b0, op_a[7:1]};
        alu_c     = op_a[0];
        alu_wr    = 1'b1;
        alu_flags = 1'b1;
      end
      default: begin
        alu_res = 8'h00;
      end
    endcase
  end

  // JZ looks at z_q, i.e. the flag as it stands entering EXEC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_valid) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = two_byte ? S_FETCH_IMM : S_EXEC;
      end
      S_FETCH_IMM: begin
        if (bus.imem_valid) begin
          imm_d   = bus.imem_data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (alu_flags) begin
          z_d = (alu_res == 8'h00);
          c_d = alu_c;
        end
        if (opcode == OP_JMP || (opcode == OP_JZ && z_q)) begin
          pc_d = ADDR_W'(imm_q);
        end
        state_d = (opcode == OP_HLT) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign bus.imem_req  = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
  assign bus.imem_addr = pc_q;
  assign bus.rf_in_1   = ir_q[3:2];
  assign bus.rf_in_2   = ir_q[1:0];
  assign bus.rf_wen    = (state_q == S_EXEC) && alu_wr;
  assign bus.rf_data   = alu_res;
  assign zero_flag     = z_q;
  assign carry_flag    = c_q;
  assign halted        = (state_q == S_HALT);

endmodule
